mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port memory responder arbitrating an instruction buffer fill and a data port.
// Define LINE_BUF_EN to turn the single-word instruction buffer into a 4-word line buffer.
module mem_responder #(
   parameter int unsigned D_PRIORITY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_addr,
   output logic [15:0] instr,
   output logic        i_rdy,
   input  logic [15:0] d_addr,
   input  logic        re,
   input  logic        we,
   input  logic [15:0] wrt_data,
   output logic [15:0] rd_data,
   output logic        d_rdy,
   output logic [15:0] m_addr,
   output logic        m_re,
   output logic        m_we,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   input  logic        m_valid
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] IFETCH = 3'd1;
   localparam logic [2:0] DREAD  = 3'd2;
   localparam logic [2:0] DWRITE = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

`ifdef LINE_BUF_EN
   localparam int unsigned TagW = 14;
`else
   localparam int unsigned TagW = 16;
`endif

   logic [2:0]      state_q, state_d;
   logic [15:0]     m_addr_q, m_addr_d;
   logic            m_re_q, m_re_d;
   logic            m_we_q, m_we_d;
   logic [15:0]     m_wdata_q, m_wdata_d;
   logic [15:0]     rd_data_q, rd_data_d;
   logic            valid_q, valid_d;
   logic [TagW-1:0] tag_q, tag_d;

   logic [TagW-1:0] i_tag, d_tag, f_tag;
   logic [15:0]     fetch_base;
   logic [15:0]     buf_rword;
   logic            fill_last;
   logic            fill_we, coh_we;
   logic            i_hit, d_hit, d_req;

`ifdef LINE_BUF_EN
   logic [15:0] buf_q [4];

   assign i_tag      = i_addr[15:2];
   assign d_tag      = d_addr[15:2];
   assign f_tag      = m_addr_q[15:2];
   assign fetch_base = {i_addr[15:2], 2'b00};
   assign buf_rword  = buf_q[i_addr[1:0]];
   assign fill_last  = (m_addr_q[1:0] == 2'b11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      end else if (fill_we) begin
         buf_q[m_addr_q[1:0]] <= m_rdata;
      end else if (coh_we) begin
         buf_q[d_addr[1:0]] <= wrt_data;
      end
   end
`else
   logic [15:0] buf_q;

   assign i_tag      = i_addr;
   assign d_tag      = d_addr;
   assign f_tag      = m_addr_q;
   assign fetch_base = i_addr;
   assign buf_rword  = buf_q;
   assign fill_last  = 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (fill_we) begin
         buf_q <= m_rdata;
      end else if (coh_we) begin
         buf_q <= wrt_data;
      end
   end
`endif

   assign i_hit = valid_q && (tag_q == i_tag);
   assign d_hit = valid_q && (tag_q == d_tag);
   assign d_req = re || we;

   always_comb begin
      state_d   = state_q;
      m_addr_d  = m_addr_q;
      m_re_d    = m_re_q;
      m_we_d    = m_we_q;
      m_wdata_d = m_wdata_q;
      rd_data_d = rd_data_q;
      valid_d   = valid_q;
      tag_d     = tag_q;
      fill_we   = 1'b0;
      coh_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (d_req && (i_hit || (D_PRIORITY != 0))) begin
               state_d   = we ? DWRITE : DREAD;
               m_addr_d  = d_addr;
               m_re_d    = re;
               m_we_d    = we;
               m_wdata_d = we ? wrt_data : m_wdata_q;
            end else if (!i_hit) begin
               state_d  = IFETCH;
               m_addr_d = fetch_base;
               m_re_d   = 1'b1;
               valid_d  = 1'b0;
            end
         end
         IFETCH: begin
            // Strobe is low for one cycle between line words; m_valid is ignored then.
            if (!m_re_q) begin
               m_re_d = 1'b1;
            end else if (m_valid) begin
               m_re_d  = 1'b0;
               fill_we = 1'b1;
               if (fill_last) begin
                  valid_d = 1'b1;
                  tag_d   = f_tag;
                  state_d = IDLE;
               end else begin
                  m_addr_d = m_addr_q + 16'd1;
               end
            end
         end
         DREAD: begin
            if (m_valid) begin
               rd_data_d = m_rdata;
               m_re_d    = 1'b0;
               state_d   = DONE;
            end
         end
         DWRITE: begin
            if (m_valid) begin
               m_we_d  = 1'b0;
               coh_we  = d_hit;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_addr_q  <= '0;
         m_re_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_wdata_q <= '0;
         rd_data_q <= '0;
         valid_q   <= 1'b0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         m_addr_q  <= m_addr_d;
         m_re_q    <= m_re_d;
         m_we_q    <= m_we_d;
         m_wdata_q <= m_wdata_d;
         rd_data_q <= rd_data_d;
         valid_q   <= valid_d;
         tag_q     <= tag_d;
      end
   end

   assign i_rdy   = i_hit;
   assign instr   = i_hit ? buf_rword : '0;
   assign rd_data = rd_data_q;
   assign d_rdy   = (state_q == DONE) ||
                    ((state_q != DREAD) && (state_q != DWRITE) && !d_req);
   assign m_addr  = m_addr_q;
   assign m_re    = m_re_q;
   assign m_we    = m_we_q;
   assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a variable-latency backing memory model.
module tb_mem_responder;

`ifdef LINE_BUF_EN
   localparam int Words = 4;
   localparam logic [15:0] RefetchExp = 16'hBEEF;
`else
   localparam int Words = 1;
   localparam logic [15:0] RefetchExp = 16'hA585;
`endif

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] exp_rd;
      int          exp_cyc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] i_addr, instr, d_addr, wrt_data, rd_data, m_addr, m_wdata, m_rdata;
   logic        i_rdy, re, we, d_rdy, m_re, m_we, m_valid;

   int          checks = 0;
   int          errors = 0;
   int          lat = 2;
   int          cnt = 0;
   int          acc_cnt = 0;
   int          wn = 0;
   logic        mv_q = 1'b0;
   logic        mv_force = 1'b0;
   logic        prev_stb = 1'b0;
   logic [15:0] rdata_q = '0;
   logic [15:0] wa [8];
   logic [15:0] wd [8];

   always #5 clk = ~clk;

   mem_responder #(.D_PRIORITY(1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_addr  (i_addr),
      .instr   (instr),
      .i_rdy   (i_rdy),
      .d_addr  (d_addr),
      .re      (re),
      .we      (we),
      .wrt_data(wrt_data),
      .rd_data (rd_data),
      .d_rdy   (d_rdy),
      .m_addr  (m_addr),
      .m_re    (m_re),
      .m_we    (m_we),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_valid (m_valid)
   );

   assign m_valid = mv_q | mv_force;
   assign m_rdata = mv_force ? 16'hDEAD : rdata_q;

   // Unwritten words read as addr ^ 0xA5A5; later writes override.
   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      logic [15:0] v = a ^ 16'hA5A5;
      for (int i = 0; i < 8; i++) if (i < wn && wa[i] == a) v = wd[i];
      return v;
   endfunction

   always @(posedge clk) begin
      prev_stb <= m_re | m_we;
      if ((m_re | m_we) && !prev_stb) acc_cnt <= acc_cnt + 1;
      if (mv_q) begin
         mv_q <= 1'b0;
         cnt  <= 0;
      end else if (m_re | m_we) begin
         if (cnt == lat - 1) begin
            mv_q <= 1'b1;
            cnt  <= 0;
            if (m_re) rdata_q <= mem_rd(m_addr);
            else if (wn < 8) begin
               wa[wn] <= m_addr;
               wd[wn] <= m_wdata;
               wn     <= wn + 1;
            end
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         cnt <= 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic d_op(input bit wr, input logic [15:0] a, input logic [15:0] wdat,
                       output int cyc);
      @(negedge clk);
      d_addr = a; wrt_data = wdat; re = !wr; we = wr; cyc = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1; cyc++;
         if (d_rdy) break;
      end
      re = 1'b0; we = 1'b0;
      @(posedge clk);
   endtask

   task automatic wait_i(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (i_rdy) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      vec_t vecs [6];
      int   cyc, a0, pulses;
      bit   ok;

      vecs[0] = '{wr:1'b0, addr:16'h0200, wdata:16'h0000, lat:1, exp_rd:16'hA7A5, exp_cyc:3};
      vecs[1] = '{wr:1'b1, addr:16'h0300, wdata:16'h1111, lat:3, exp_rd:16'hA7A5, exp_cyc:5};
      vecs[2] = '{wr:1'b0, addr:16'h0300, wdata:16'h0000, lat:2, exp_rd:16'h1111, exp_cyc:4};
      vecs[3] = '{wr:1'b0, addr:16'hFFFF, wdata:16'h0000, lat:4, exp_rd:16'h5A5A, exp_cyc:6};
      vecs[4] = '{wr:1'b1, addr:16'hFFFF, wdata:16'h0000, lat:1, exp_rd:16'h5A5A, exp_cyc:3};
      vecs[5] = '{wr:1'b0, addr:16'hFFFF, wdata:16'h0000, lat:1, exp_rd:16'h0000, exp_cyc:3};

      rst_n = 1'b0; re = 1'b0; we = 1'b0;
      i_addr = 16'h0000; d_addr = '0; wrt_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_i_rdy", i_rdy, 0);
      check("rst_instr", instr, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_m_re", m_re, 0);
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_d_rdy", d_rdy, 1);

      // First fill at latency 2
      @(negedge clk);
      rst_n = 1'b1; a0 = acc_cnt; cyc = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1; cyc++;
         if (i_rdy) break;
      end
      check("fill_cycles", cyc, Words * (lat + 2));
      check("fill_instr", instr, 16'hA5A5);
      check("fill_accesses", acc_cnt - a0, Words);
`ifdef LINE_BUF_EN
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         i_addr = 16'(i);
         #1;
         check("line_hit", i_rdy, 1);
         check("line_word", instr, 16'(i) ^ 16'hA5A5);
      end
      repeat (3) @(posedge clk);
      #1;
      check("line_no_refetch", acc_cnt - a0, 4);
`endif

      for (int v = 0; v < 6; v++) begin
         lat = vecs[v].lat;
         a0  = acc_cnt;
         d_op(vecs[v].wr, vecs[v].addr, vecs[v].wdata, cyc);
         check("vec_rd_data", rd_data, vecs[v].exp_rd);
         check("vec_cycles", cyc, vecs[v].exp_cyc);
         check("vec_accesses", acc_cnt - a0, 1);
      end

      // Simultaneous miss and read: data side goes first
      lat = 2;
      @(negedge clk);
      i_addr = 16'h0010; d_addr = 16'h0100; re = 1'b1; a0 = acc_cnt;
      @(posedge clk); #1;
      check("prio_m_re", m_re, 1);
      check("prio_m_addr", m_addr, 16'h0100);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (d_rdy) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("prio_d_rdy", ok, 1);
      check("prio_rd_data", rd_data, 16'hA4A5);
      check("prio_i_waits", i_rdy, 0);
      re = 1'b0;
      wait_i(ok);
      check("prio_fetch_done", ok, 1);
      check("prio_instr", instr, 16'hA5B5);
      check("prio_accesses", acc_cnt - a0, 1 + Words);

      // Write hitting the buffered word updates it without a refetch
      @(negedge clk);
      i_addr = 16'h0004;
      wait_i(ok);
      check("coh_fetch_done", ok, 1);
      a0 = acc_cnt;
      d_op(1'b1, 16'h0004, 16'hBEEF, cyc);
      #1;
      check("coh_instr", instr, 16'hBEEF);
      check("coh_i_rdy", i_rdy, 1);
      repeat (5) @(posedge clk);
      #1;
      check("coh_no_refetch", acc_cnt - a0, 1);
      check("coh_instr_hold", instr, 16'hBEEF);

      // Back-to-back latency-1 reads
      lat = 1;
      @(negedge clk);
      a0 = acc_cnt; pulses = 0; d_addr = 16'h0200; re = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (d_rdy) begin
            pulses++;
            if (pulses == 1) begin
               check("b2b_rd0", rd_data, 16'hA7A5);
               d_addr = 16'h0201;
               @(posedge clk); #1;
               check("b2b_pulse_width", d_rdy, 0);
            end else begin
               check("b2b_rd1", rd_data, 16'hA7A4);
               re = 1'b0;
               break;
            end
         end
      end
      @(posedge clk); #1;
      check("b2b_pulses", pulses, 2);
      check("b2b_accesses", acc_cnt - a0, 2);

`ifndef LINE_BUF_EN
      // i_addr moving mid-fetch: entry keeps the address latched at fetch start
      lat = 3;
      @(negedge clk);
      i_addr = 16'h0020;
      @(posedge clk); #1;
      check("mid_m_addr", m_addr, 16'h0020);
      @(negedge clk);
      i_addr = 16'h0040;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (!m_re) begin ok = 1'b1; break; end
      end
      check("mid_fetch_done", ok, 1);
      i_addr = 16'h0020;
      #1;
      check("mid_tag_hit", i_rdy, 1);
      check("mid_instr", instr, 16'hA585);
`endif

      // Reset during a slow read, then a stray m_valid
      lat = 5;
      @(negedge clk);
      d_addr = 16'h0300; re = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      check("rst_mid_busy", m_re, 1);
      rst_n = 1'b0;
      #1;
      re = 1'b0;
      check("rst_mid_m_re", m_re, 0);
      check("rst_mid_rd_data", rd_data, 0);
      check("rst_mid_i_rdy", i_rdy, 0);
      check("rst_mid_instr", instr, 0);
      check("rst_mid_m_addr", m_addr, 0);
      check("rst_mid_m_wdata", m_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1; mv_force = 1'b1;
      @(posedge clk); #1;
      mv_force = 1'b0;
      check("late_valid_rd_data", rd_data, 0);
      check("late_valid_i_rdy", i_rdy, 0);
      wait_i(ok);
      check("refetch_done", ok, 1);
      check("refetch_instr", instr, RefetchExp);
      check("refetch_rd_data", rd_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
